// File: rtl/rb_pkg.sv
// Shared types and helpers for the ringbuffer write arbiter.
package rb_pkg;

  // Upper bounds for the generic round-robin helper.
  localparam int unsigned RB_MAX_REQ  = 32;
  localparam int unsigned RB_MAX_ID_W = 5;

  // Default slice widths, used by the default entry layout.
  localparam int unsigned RB_DEF_NUM_REQ = 4;
  localparam int unsigned RB_DEF_DATA_W  = 128;
  localparam int unsigned RB_DEF_ID_W    = $clog2(RB_DEF_NUM_REQ);

  typedef enum logic {
    IDLE,
    GRANT
  } rb_arb_state_t;

  // Layout of one ringbuffer entry at the default widths: {id, last, data}.
  typedef struct packed {
    logic [RB_DEF_ID_W-1:0]   id;
    logic                     last;
    logic [RB_DEF_DATA_W-1:0] data;
  } rb_entry_t;

  // First set index of valid after ptr, searching cyclically over n requesters.
  function automatic logic [RB_MAX_ID_W-1:0] rr_pick(
    input logic [RB_MAX_REQ-1:0]  valid,
    input logic [RB_MAX_ID_W-1:0] ptr,
    input int unsigned            n
  );
    logic [RB_MAX_ID_W-1:0] pick;
    logic                   found;
    int unsigned            idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= RB_MAX_REQ; i++) begin
      if (i <= n) begin
        idx = (32'(ptr) + i) % n;
        if (!found && valid[idx[RB_MAX_ID_W-1:0]]) begin
          pick  = idx[RB_MAX_ID_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rb_wr_arbiter_rr_select.sv
// Combinational round-robin picker: first valid requester after ptr.
module rr_select
  import rb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    pick,
  output logic               any
);

  // Priority rotates so the index right after ptr wins.
  always_comb begin
    any  = |valid;
    pick = ID_W'(rr_pick(RB_MAX_REQ'(valid), RB_MAX_ID_W'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/rb_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one ringbuffer write port.
module rb_wr_arbiter
  import rb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BEATS = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rb_wr_en,
  output logic [DATA_W+ID_W:0]      rb_din,
  input  logic                      rb_full,
  output logic                      busy,
  output logic                      overrun_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  rb_arb_state_t    state, state_next;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [ID_W-1:0]   pick;
  logic              any_valid;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              accept;
  logic              at_max;
  logic              end_pkt;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .pick  (pick),
    .any   (any_valid)
  );

  // Granted requester's view and beat-acceptance conditions.
  always_comb begin
    g_valid = req_valid[grant];
    g_last  = req_last[grant];
    g_data  = req_data[int'(grant)*DATA_W +: DATA_W];
    accept  = (state == GRANT) && g_valid && !rb_full;
    at_max  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    end_pkt = accept && (g_last || at_max);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state: arbitrate in IDLE, hold grant until the packet's final beat.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (any_valid) state_next = GRANT;
      GRANT: if (end_pkt)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, round-robin pointer, beat counter and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant       <= '0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant    <= pick;
        rr_ptr   <= pick;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (accept && at_max && !g_last) overrun_err <= 1'b1;
    end
  end

  // Outputs: only the granted requester sees ready, and never while full.
  always_comb begin
    req_ready = '0;
    rb_wr_en  = 1'b0;
    busy      = (state == GRANT);
    if (state == GRANT) begin
      req_ready[grant] = !rb_full;
      rb_wr_en         = g_valid && !rb_full;
    end
    // A packet cut at MAX_BEATS is closed by forcing last on its final beat.
    rb_din = {grant, g_last || at_max, g_data};
  end

endmodule
